ldmstm_sequencer: RTL and testbench

LDMSTM_SEQUENCER -- requirements
Module: ldmstm_sequencer

---
 rtl/ldmstm_sequencer_pkg.sv | 22 ++
 rtl/ldmstm_lowest_set.sv | 25 ++
 rtl/ldmstm_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ldmstm_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ldmstm_sequencer_pkg.sv
//==============================================================================
// Module   : ldmstm_sequencer_pkg
// Purpose  : Shared ARM_Constants definitions for the LDM/STM sequencer:
//            state encoding and the word address step.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package ldmstm_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] ADDR_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/ldmstm_lowest_set.sv
//==============================================================================
// Module   : ldmstm_lowest_set
// Purpose  : Combinational lowest-set-bit finder over a 16-entry register list.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ldmstm_lowest_set (
  input  logic [15:0] list_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  // Scan downwards so the lowest set bit is the last one to win.
  always_comb begin
    idx_o   = 4'd0;
    valid_o = |list_i;
    for (int i = 15; i >= 0; i--) begin
      if (list_i[i]) idx_o = i[3:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ldmstm_sequencer.sv
//==============================================================================
// Module   : ldmstm_sequencer
// Purpose  : Sequences the transfers of an ARM LDM/STM block instruction.
//            Base writeback state is built only with LDMSTM_WRITEBACK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ldmstm_sequencer
  import ldmstm_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [15:0] reglist,
  input  logic [31:0] base,
  input  logic        up,
  input  logic        pre,
  input  logic        load,
  input  logic        wb,
  output logic        busy,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [3:0]  reg_num,
  output logic        done,
  output logic        wb_valid,
  output logic [31:0] wb_data
);

  state_e      state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [31:0] addr_q, addr_d;
  logic        load_q, load_d;
  logic [4:0]  count;
  logic [31:0] span;
  logic [31:0] first_addr;
  logic [3:0]  low_idx;
  logic        low_valid;
  logic        last_xfer;
  state_e      fin_start;
  state_e      fin_xfer;

  ldmstm_lowest_set u_lowest_set (
    .list_i  (list_q),
    .idx_o   (low_idx),
    .valid_o (low_valid)
  );

  always_comb begin
    count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      count = count + {4'd0, reglist[i]};
    end
  end

  assign span = 32'(count) * ADDR_STEP;

  // Transfers always walk upwards, so a descending block starts at its bottom.
  always_comb begin
    case ({up, pre})
      2'b10:   first_addr = base;
      2'b11:   first_addr = base + ADDR_STEP;
      2'b00:   first_addr = base - span + ADDR_STEP;
      default: first_addr = base - span;
    endcase
  end

  assign last_xfer = ((list_q & (list_q - 16'd1)) == 16'd0);

`ifdef LDMSTM_WRITEBACK_EN
  logic        wb_q, wb_d;
  logic [31:0] wbval_q, wbval_d;

  assign fin_start = wb   ? ST_WB : ST_DONE;
  assign fin_xfer  = wb_q ? ST_WB : ST_DONE;
  assign wb_valid  = (state_q == ST_WB);
  assign wb_data   = wb_valid ? wbval_q : 32'd0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wb_q    <= 1'b0;
      wbval_q <= 32'd0;
    end else begin
      wb_q    <= wb_d;
      wbval_q <= wbval_d;
    end
  end

  always_comb begin
    wb_d    = wb_q;
    wbval_d = wbval_q;
    if (state_q == ST_IDLE && start) begin
      wb_d    = wb;
      wbval_d = up ? (base + span) : (base - span);
    end
  end
`else
  logic unused_wb;

  assign unused_wb = wb;
  assign fin_start = ST_DONE;
  assign fin_xfer  = ST_DONE;
  assign wb_valid  = 1'b0;
  assign wb_data   = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      list_q  <= 16'd0;
      addr_q  <= 32'd0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    load_d  = load_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          list_d  = reglist;
          addr_d  = first_addr;
          load_d  = load;
          state_d = (reglist == 16'd0) ? fin_start : ST_XFER;
        end
      end
      ST_XFER: begin
        if (mem_req && mem_ack) begin
          list_d = list_q & ~(16'd1 << low_idx);
          addr_d = addr_q + ADDR_STEP;
          if (last_xfer) state_d = fin_xfer;
        end
      end
`ifdef LDMSTM_WRITEBACK_EN
      ST_WB:   state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign mem_req  = (state_q == ST_XFER) && low_valid;
  assign mem_addr = mem_req ? addr_q  : 32'd0;
  assign reg_num  = mem_req ? low_idx : 4'd0;
  assign mem_rd   = mem_req ? load_q  : 1'b0;
  assign done     = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ldmstm_sequencer.sv
//==============================================================================
// Module   : tb_ldmstm_sequencer
// Purpose  : Directed self-checking bench for ldmstm_sequencer; follows the
//            LDMSTM_WRITEBACK_EN build option of the design.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ldmstm_sequencer;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic [15:0] reglist;
  logic [31:0] base;
  logic        up, pre, load, wb;
  logic        busy, mem_req, mem_ack, mem_rd, done, wb_valid;
  logic [31:0] mem_addr, wb_data;
  logic [3:0]  reg_num;

  int checks = 0;
  int errors = 0;

  ldmstm_sequencer dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .reglist  (reglist),
    .base     (base),
    .up       (up),
    .pre      (pre),
    .load     (load),
    .wb       (wb),
    .busy     (busy),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .reg_num  (reg_num),
    .done     (done),
    .wb_valid (wb_valid),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".busy"},     {31'd0, busy},     32'd0);
    chk({tag, ".mem_req"},  {31'd0, mem_req},  32'd0);
    chk({tag, ".mem_addr"}, mem_addr,          32'd0);
    chk({tag, ".mem_rd"},   {31'd0, mem_rd},   32'd0);
    chk({tag, ".reg_num"},  {28'd0, reg_num},  32'd0);
    chk({tag, ".done"},     {31'd0, done},     32'd0);
    chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, ".wb_data"},  wb_data,           32'd0);
  endtask

  task automatic chk_xfer(input string tag, input logic [3:0] r, input logic [31:0] a, input logic rd);
    chk({tag, ".req"},  {31'd0, mem_req}, 32'd1);
    chk({tag, ".reg"},  {28'd0, reg_num}, {28'd0, r});
    chk({tag, ".addr"}, mem_addr,         a);
    chk({tag, ".rd"},   {31'd0, mem_rd},  {31'd0, rd});
  endtask

  // Completion after the last transfer: optional writeback cycle, then done.
  task automatic chk_finish(input string tag, input logic exp_wb, input logic [31:0] wbval);
`ifdef LDMSTM_WRITEBACK_EN
    if (exp_wb) begin
      chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
      chk({tag, ".wb_data"},  wb_data,           wbval);
      chk({tag, ".done_early"}, {31'd0, done},   32'd0);
      tick();
    end
`else
    chk({tag, ".wbval_unused"}, wbval & {32{exp_wb & 1'b0}}, 32'd0);
`endif
    chk({tag, ".done"},     {31'd0, done},     32'd1);
    chk({tag, ".wb_valid0"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, ".mem_req0"}, {31'd0, mem_req},  32'd0);
    tick();
    chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".idle_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic launch(input logic [15:0] rl, input logic [31:0] b,
                        input logic u, input logic p, input logic l, input logic w);
    reglist = rl; base = b; up = u; pre = p; load = l; wb = w;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0; start = 1'b0; reglist = 16'd0; base = 32'd0;
    up = 1'b0; pre = 1'b0; load = 1'b0; wb = 1'b0; mem_ack = 1'b0;
    #2;
    chk_idle_outputs("reset");
    tick(); tick();
    rst_b = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    // Up / post-increment streaming with ack held high.
    mem_ack = 1'b1;
    launch(16'h00F0, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk_xfer($sformatf("ia%0d", k), 4'(4 + k), 32'h1000 + 32'(4 * k), 1'b1);
      chk($sformatf("ia%0d.busy", k), {31'd0, busy}, 32'd1);
      tick();
    end
    chk_finish("ia", 1'b1, 32'h0000_1010);

    // Down / pre-decrement with three stall cycles per transfer.
    mem_ack = 1'b0;
    launch(16'h8001, 32'h0000_2000, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int t = 0; t < 2; t++) begin
      for (int s = 0; s < 3; s++) begin
        chk_xfer($sformatf("db%0d.stall%0d", t, s), (t == 0) ? 4'd0 : 4'd15,
                 32'h1FF8 + 32'(4 * t), 1'b0);
        tick();
      end
      mem_ack = 1'b1;
      chk_xfer($sformatf("db%0d.ack", t), (t == 0) ? 4'd0 : 4'd15,
               32'h1FF8 + 32'(4 * t), 1'b0);
      tick();
      mem_ack = 1'b0;
    end
    chk_finish("db", 1'b1, 32'h0000_1FF8);

    // Empty list: no request ever, writeback of unchanged base.
    mem_ack = 1'b1;
    launch(16'h0000, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("empty.mem_req", {31'd0, mem_req}, 32'd0);
    chk("empty.busy", {31'd0, busy}, 32'd1);
    chk_finish("empty", 1'b1, 32'h0000_0040);

    // Address wrap at 2^32.
    launch(16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_xfer("wrap0", 4'd0, 32'hFFFF_FFFC, 1'b1);
    tick();
    chk_xfer("wrap1", 4'd1, 32'h0000_0000, 1'b1);
    tick();
    chk_finish("wrap", 1'b0, 32'd0);

    // Reset after the fifth ack of a full list.
    launch(16'hFFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    chk_xfer("pre_rst", 4'd5, 32'h0000_0014, 1'b1);
    rst_b = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("rst_hold%0d.done", k), {31'd0, done}, 32'd0);
    end
    rst_b = 1'b1;
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("after_rst%0d.done", k), {31'd0, done}, 32'd0);
      chk($sformatf("after_rst%0d.wb_valid", k), {31'd0, wb_valid}, 32'd0);
      chk($sformatf("after_rst%0d.busy", k), {31'd0, busy}, 32'd0);
    end

    // Fresh transfer after reset; start pulsed while busy must be dropped.
    mem_ack = 1'b1;
    launch(16'h0003, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_xfer("ign0", 4'd0, 32'h0000_0100, 1'b1);
    reglist = 16'hFFFF; base = 32'h0000_8000; start = 1'b1;
    tick();
    start = 1'b0;
    chk_xfer("ign1", 4'd1, 32'h0000_0104, 1'b1);
    tick();
    chk_finish("ign", 1'b0, 32'd0);
    tick();
    chk("ign.no_queue_busy", {31'd0, busy}, 32'd0);
    chk("ign.no_queue_req", {31'd0, mem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
